nearest_hit_reducer: RTL and testbench

//  Parametrised argmin stage for the block selector: takes per-block ray/block hit flags and float t values
//  for one pixel per beat, and returns the nearest-hit block index and t.

---
 rtl/nearest_hit_reducer_if.sv | 39 +++
 rtl/nearest_hit_reducer.sv | 149 ++++++++++++++
 tb/tb_nearest_hit_reducer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/nearest_hit_reducer_if.sv
// nearest_hit_reducer_if
//   Beat-in / result-out bundle for the nearest-hit argmin stage.
//   Upstream side: valid_in/ready_in handshake, per-block hit flags and
//   IEEE-754 single t values, plus pixel x/y and ray direction sideband.
//   Downstream side: valid_out/ready_out handshake, winning block index and
//   t, plus the sideband re-aligned with the result.
//   Modports:
//     slave  - the reducer itself (consumes beats, produces results)
//     master - the producer/consumer environment around it
interface nearest_hit_reducer_if #(
  parameter int NUM_BLOCKS = 12,
  parameter int IDX_W      = $clog2(NUM_BLOCKS + 1)
);
  logic                         valid_in;
  logic                         ready_in;
  logic [NUM_BLOCKS-1:0]        hit_in;
  logic [NUM_BLOCKS-1:0][31:0]  t_in;
  logic [10:0]                  x_in;
  logic [9:0]                   y_in;
  logic [2:0][31:0]             ray_in;

  logic                         valid_out;
  logic                         ready_out;
  logic [IDX_W-1:0]             best_block;
  logic [31:0]                  best_t;
  logic [10:0]                  x_out;
  logic [9:0]                   y_out;
  logic [2:0][31:0]             ray_out;

  modport slave (
    input  valid_in, hit_in, t_in, x_in, y_in, ray_in, ready_out,
    output ready_in, valid_out, best_block, best_t, x_out, y_out, ray_out
  );

  modport master (
    output valid_in, hit_in, t_in, x_in, y_in, ray_in, ready_out,
    input  ready_in, valid_out, best_block, best_t, x_out, y_out, ray_out
  );
endinterface

// File: rtl/nearest_hit_reducer.sv
// nearest_hit_reducer
//   Argmin stage for the block selector. Each beat carries one pixel's
//   per-block hit flags and t values; the block returns the index and t of
//   the nearest valid hit, or NO_HIT (all ones) with t = -1.0 when no lane
//   qualifies. A registered binary reduction tree gives a fixed latency of
//   LEVELS+1 cycles; pixel x/y and ray direction ride alongside in a shift
//   register of the same depth and enable.
//   Ports:
//     clk_in  - clock
//     rst_in  - asynchronous active-high reset, discards all in-flight beats
//     bus     - nearest_hit_reducer_if.slave (handshakes, data, sideband)
module nearest_hit_reducer #(
  parameter int NUM_BLOCKS = 12,
  parameter int IDX_W      = $clog2(NUM_BLOCKS + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  nearest_hit_reducer_if.slave  bus
);

  localparam int               LEVELS   = $clog2(NUM_BLOCKS);
  localparam int               HALF     = (NUM_BLOCKS + 1) / 2;
  localparam int               SB_W     = 96 + 10 + 11;
  localparam logic [IDX_W-1:0] NO_HIT   = '1;
  localparam logic [31:0]      T_NO_HIT = 32'hBF80_0000;

  typedef struct packed {
    logic             cand;
    logic [IDX_W-1:0] idx;
    logic [30:0]      t;
  } lane_t;

  // Negative values (including -0.0), Inf and NaN are treated as misses.
  function automatic lane_t qualify(input logic hit, input logic [31:0] t,
                                    input logic [IDX_W-1:0] idx);
    lane_t r;
    r.cand = hit && !t[31] && (t[30:23] != 8'hFF);
    r.idx  = idx;
    r.t    = t[30:0];
    return r;
  endfunction

  // For non-negative finite floats the magnitude bits order like unsigned
  // integers. The left (lower-index) operand is kept on equal t.
  function automatic lane_t nearer(input lane_t a, input lane_t b);
    if (b.cand && (!a.cand || (b.t < a.t))) return b;
    return a;
  endfunction

  logic advance;
  lane_t fin;

  assign advance     = bus.ready_out | ~bus.valid_out;
  assign bus.ready_in = advance;

  // ---- valid and sideband shift register, LEVELS+1 deep ----
  logic            vld_p [LEVELS+1];
  logic [SB_W-1:0] sb_p  [LEVELS+1];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k <= LEVELS; k++) begin
        vld_p[k] <= 1'b0;
        sb_p[k]  <= '0;
      end
    end else if (advance) begin
      vld_p[0] <= bus.valid_in;
      sb_p[0]  <= {bus.ray_in, bus.y_in, bus.x_in};
      for (int k = 1; k <= LEVELS; k++) begin
        vld_p[k] <= vld_p[k-1];
        sb_p[k]  <= sb_p[k-1];
      end
    end
  end

  assign bus.valid_out = vld_p[LEVELS];
  assign {bus.ray_out, bus.y_out, bus.x_out} = sb_p[LEVELS];

  generate
    if (LEVELS == 0) begin : g_single
      // A single lane needs no tree: qualify straight into the output register.
      assign fin = qualify(bus.hit_in[0], bus.t_in[0], '0);
    end else begin : g_tree
      // tree_p[0] holds the qualified lanes; tree_p[l] holds level l of the
      // reduction. One spare lane lets the odd-leftover read stay in range.
      lane_t tree_d [LEVELS][NUM_BLOCKS+1];
      lane_t tree_p [LEVELS][NUM_BLOCKS+1];

      always_comb begin
        int w_prev;
        int w_cur;
        for (int l = 0; l < LEVELS; l++)
          for (int i = 0; i <= NUM_BLOCKS; i++)
            tree_d[l][i] = '0;
        w_prev = NUM_BLOCKS;
        w_cur  = NUM_BLOCKS;

        // ---- stage 0: lane qualification ----
        for (int i = 0; i < NUM_BLOCKS; i++)
          tree_d[0][i] = qualify(bus.hit_in[i], bus.t_in[i], IDX_W'(i));

        // ---- stages 1..LEVELS-1: pairwise reduction ----
        for (int l = 1; l < LEVELS; l++) begin
          w_cur = (w_prev + 1) / 2;
          for (int i = 0; i < HALF; i++) begin
            if (i < w_cur) begin
              if (2 * i + 1 < w_prev)
                tree_d[l][i] = nearer(tree_p[l-1][2*i], tree_p[l-1][2*i+1]);
              else
                tree_d[l][i] = tree_p[l-1][2*i];
            end
          end
          w_prev = w_cur;
        end
      end

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          for (int l = 0; l < LEVELS; l++)
            for (int i = 0; i <= NUM_BLOCKS; i++)
              tree_p[l][i] <= '0;
        end else if (advance) begin
          tree_p <= tree_d;
        end
      end

      // The last tree level always holds exactly two lanes.
      assign fin = nearer(tree_p[LEVELS-1][0], tree_p[LEVELS-1][1]);
    end
  endgenerate

  // ---- output stage: final compare, no-hit substitution ----
  logic [IDX_W-1:0] best_block_p;
  logic [31:0]      best_t_p;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      best_block_p <= NO_HIT;
      best_t_p     <= '0;
    end else if (advance) begin
      best_block_p <= fin.cand ? fin.idx : NO_HIT;
      best_t_p     <= fin.cand ? {1'b0, fin.t} : T_NO_HIT;
    end
  end

  assign bus.best_block = best_block_p;
  assign bus.best_t     = best_t_p;

endmodule

// File: tb/tb_nearest_hit_reducer.sv
// tb_nearest_hit_reducer
//   Directed bench for nearest_hit_reducer built at NUM_BLOCKS = 12, 7 and 1.
//   Every expected value below is hand-derived from the float encodings.
module tb_nearest_hit_reducer;

  logic clk_in;
  logic rst_in;

  nearest_hit_reducer_if #(.NUM_BLOCKS(12)) b12 ();
  nearest_hit_reducer_if #(.NUM_BLOCKS(7))  b7 ();
  nearest_hit_reducer_if #(.NUM_BLOCKS(1))  b1 ();

  nearest_hit_reducer #(.NUM_BLOCKS(12)) u12 (.clk_in(clk_in), .rst_in(rst_in), .bus(b12));
  nearest_hit_reducer #(.NUM_BLOCKS(7))  u7  (.clk_in(clk_in), .rst_in(rst_in), .bus(b7));
  nearest_hit_reducer #(.NUM_BLOCKS(1))  u1  (.clk_in(clk_in), .rst_in(rst_in), .bus(b1));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // One isolated beat into the 12-lane build; latency, index, t and sideband.
  task automatic beat12(input string tag, input logic [11:0] hit, input logic [11:0][31:0] tv,
                        input logic [10:0] x, input logic [9:0] y, input logic [95:0] ray,
                        input logic [3:0] exp_blk, input logic [31:0] exp_t);
    int lat;
    @(posedge clk_in); #1;
    b12.hit_in = hit; b12.t_in = tv; b12.x_in = x; b12.y_in = y; b12.ray_in = ray;
    b12.valid_in = 1'b1;
    check({tag, " ready_in"}, b12.ready_in, 1'b1);
    @(posedge clk_in); #1;
    b12.valid_in = 1'b0;
    lat = 1;
    while (!b12.valid_out && lat < 20) begin @(posedge clk_in); #1; lat++; end
    check({tag, " latency"}, lat, 5);
    check({tag, " block"}, b12.best_block, exp_blk);
    check({tag, " t"}, b12.best_t, exp_t);
    check({tag, " sideband"}, {b12.x_out, b12.y_out, b12.ray_out}, {x, y, ray});
  endtask

  task automatic beat7(input string tag, input logic [6:0] hit, input logic [6:0][31:0] tv,
                       input logic [2:0] exp_blk, input logic [31:0] exp_t);
    int lat;
    @(posedge clk_in); #1;
    b7.hit_in = hit; b7.t_in = tv; b7.valid_in = 1'b1;
    @(posedge clk_in); #1;
    b7.valid_in = 1'b0;
    lat = 1;
    while (!b7.valid_out && lat < 20) begin @(posedge clk_in); #1; lat++; end
    check({tag, " latency"}, lat, 4);
    check({tag, " block"}, b7.best_block, exp_blk);
    check({tag, " t"}, b7.best_t, exp_t);
  endtask

  task automatic beat1(input string tag, input logic hit, input logic [31:0] t,
                       input logic exp_blk, input logic [31:0] exp_t);
    int lat;
    @(posedge clk_in); #1;
    b1.hit_in = hit; b1.t_in = t; b1.valid_in = 1'b1;
    @(posedge clk_in); #1;
    b1.valid_in = 1'b0;
    lat = 1;
    while (!b1.valid_out && lat < 20) begin @(posedge clk_in); #1; lat++; end
    check({tag, " latency"}, lat, 1);
    check({tag, " block"}, b1.best_block, exp_blk);
    check({tag, " t"}, b1.best_t, exp_t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0][31:0] tv;
    logic [6:0][31:0]  tv7;
    logic [88:0]       cur;
    logic [88:0]       held;
    logic [88:0]       expv;
    int sent, got, cyc, idle_hits;
    bit stalled_prev;

    rst_in = 1'b1;
    b12.valid_in = 0; b12.ready_out = 1; b12.hit_in = '0; b12.t_in = '0;
    b12.x_in = '0; b12.y_in = '0; b12.ray_in = '0;
    b7.valid_in = 0; b7.ready_out = 1; b7.hit_in = '0; b7.t_in = '0;
    b7.x_in = '0; b7.y_in = '0; b7.ray_in = '0;
    b1.valid_in = 0; b1.ready_out = 1; b1.hit_in = '0; b1.t_in = '0;
    b1.x_in = '0; b1.y_in = '0; b1.ray_in = '0;

    repeat (3) @(posedge clk_in);
    #1;
    check("reset valid_out", b12.valid_out, 1'b0);
    check("reset best_block", b12.best_block, 4'hF);
    check("reset best_t", b12.best_t, 32'h0);
    check("reset sideband", {b12.x_out, b12.y_out, b12.ray_out}, 117'h0);
    check("reset ready_in", b12.ready_in, 1'b1);
    check("reset N7 block", b7.best_block, 3'h7);
    check("reset N1 block", b1.best_block, 1'b1);
    rst_in = 1'b0;

    // Single hit; other lanes carry smaller t but are not hits.
    tv = {12{32'h3C00_0000}}; tv[5] = 32'h4000_0000;
    beat12("single lane5", 12'h020, tv, 11'h001, 10'h002, 96'h3, 4'd5, 32'h4000_0000);

    tv = {12{32'h3C00_0000}};
    tv[3] = 32'h4000_0000; tv[7] = 32'h3F00_0000; tv[11] = 32'h3F80_0000;
    beat12("three hits", 12'h888, tv, 11'h123, 10'h2AB,
           96'hDEADBEEF_CAFEF00D_01234567, 4'd7, 32'h3F00_0000);

    tv = {12{32'h3C00_0000}}; tv[2] = 32'h3F80_0000; tv[9] = 32'h3F80_0000;
    beat12("tie 2v9", 12'h204, tv, 11'h7FF, 10'h3FF, 96'h0, 4'd2, 32'h3F80_0000);

    tv = {12{32'h3C00_0000}}; tv[4] = 32'h3F00_0000; tv[5] = 32'h3F00_0000;
    beat12("tie 4v5", 12'h030, tv, 11'h010, 10'h020, 96'h1, 4'd4, 32'h3F00_0000);

    tv = {12{32'h3C00_0000}}; tv[4] = 32'hBF80_0000;
    beat12("negative only", 12'h010, tv, 11'h0, 10'h0, 96'h0, 4'hF, 32'hBF80_0000);

    tv = {12{32'h3C00_0000}}; tv[4] = 32'h7FC0_0000;
    beat12("nan only", 12'h010, tv, 11'h0, 10'h0, 96'h0, 4'hF, 32'hBF80_0000);

    tv = {12{32'h3C00_0000}}; tv[4] = 32'h7F80_0000;
    beat12("inf only", 12'h010, tv, 11'h0, 10'h0, 96'h0, 4'hF, 32'hBF80_0000);

    tv = {12{32'h3C00_0000}}; tv[4] = 32'h8000_0000;
    beat12("neg zero only", 12'h010, tv, 11'h0, 10'h0, 96'h0, 4'hF, 32'hBF80_0000);

    tv = {12{32'h3C00_0000}}; tv[1] = 32'h3F80_0000; tv[8] = 32'h0000_0000;
    beat12("pos zero", 12'h102, tv, 11'h5, 10'h6, 96'h7, 4'd8, 32'h0000_0000);

    // Magnitude of -1.0 is smaller than 3.0's; the sign must disqualify it.
    tv = {12{32'h3C00_0000}}; tv[2] = 32'hBF80_0000; tv[6] = 32'h4040_0000;
    beat12("neg vs pos", 12'h044, tv, 11'h0, 10'h0, 96'h0, 4'd6, 32'h4040_0000);

    tv = {12{32'h3C00_0000}}; tv[0] = 32'h7F7F_FFFF; tv[10] = 32'h0000_0001;
    beat12("max vs denorm", 12'h401, tv, 11'h0, 10'h0, 96'h0, 4'd10, 32'h0000_0001);

    tv = {12{32'h3C00_0000}}; tv[0] = 32'h3F80_0000; tv[11] = 32'h3E80_0000;
    beat12("lane11 wins", 12'h801, tv, 11'h0, 10'h0, 96'h0, 4'd11, 32'h3E80_0000);

    // Narrower builds: lane 6 of N=7 is the odd leftover at the first level.
    tv7 = {7{32'h3C00_0000}}; tv7[6] = 32'h3F80_0000;
    beat7("n7 lane6", 7'h40, tv7, 3'd6, 32'h3F80_0000);
    tv7 = {7{32'h3C00_0000}}; tv7[0] = 32'h4000_0000; tv7[6] = 32'h3F80_0000;
    beat7("n7 lane6 vs 0", 7'h41, tv7, 3'd6, 32'h3F80_0000);
    tv7 = {7{32'h3C00_0000}}; tv7[1] = 32'h3F80_0000; tv7[5] = 32'h3F80_0000;
    beat7("n7 tie", 7'h22, tv7, 3'd1, 32'h3F80_0000);
    beat7("n7 none", 7'h00, tv7, 3'd7, 32'hBF80_0000);
    beat1("n1 hit", 1'b1, 32'h3F80_0000, 1'b0, 32'h3F80_0000);
    beat1("n1 nan", 1'b1, 32'h7FC0_0000, 1'b1, 32'hBF80_0000);

    // Streaming with a 3-cycle downstream stall in the middle.
    sent = 0; got = 0; cyc = 0; stalled_prev = 0; held = '0;
    while (got < 20 && cyc < 200) begin
      @(posedge clk_in); #1;
      b12.ready_out = !(cyc >= 9 && cyc < 12);
      if (sent < 20) begin
        b12.valid_in = 1'b1;
        b12.hit_in = 12'h001 << (sent % 12);
        tv = '0; tv[sent % 12] = 32'h3F80_0000 + 32'(sent);
        b12.t_in = tv;
        b12.x_in = 11'(sent);
        b12.y_in = 10'(3 * sent);
        b12.ray_in = {32'(sent), ~32'(sent), 32'(sent) ^ 32'h5};
      end else begin
        b12.valid_in = 1'b0;
      end
      #1;
      if (b12.valid_out) begin
        cur = {b12.best_block, b12.best_t, b12.x_out, b12.y_out, b12.ray_out[0]};
        if (!b12.ready_out) begin
          if (stalled_prev) check("stall hold", cur, held);
          check("stall ready_in", b12.ready_in, 1'b0);
          held = cur;
          stalled_prev = 1;
        end else begin
          expv = {4'(got % 12), 32'h3F80_0000 + 32'(got), 11'(got), 10'(3 * got),
                  32'(got) ^ 32'h5};
          check("stream beat", cur, expv);
          got++;
          stalled_prev = 0;
        end
      end
      if (b12.valid_in && b12.ready_in) sent++;
      cyc++;
    end
    check("stream received", got, 20);
    check("stream accepted", sent, 20);
    b12.valid_in = 1'b0; b12.ready_out = 1'b1;
    idle_hits = 0;
    repeat (8) begin
      @(posedge clk_in); #1;
      if (b12.valid_out) idle_hits++;
    end
    check("stream no duplicates", idle_hits, 0);

    // Six beats back-to-back, then reset with beats in flight.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_in); #1;
      b12.valid_in = 1'b1;
      b12.hit_in = 12'h001 << k;
      tv = '0; tv[k] = 32'h3F80_0000;
      b12.t_in = tv;
    end
    @(posedge clk_in); #1;
    b12.valid_in = 1'b0;
    check("pre-reset valid_out", b12.valid_out, 1'b1);
    rst_in = 1'b1;
    #1;
    check("async reset valid_out", b12.valid_out, 1'b0);
    check("async reset best_block", b12.best_block, 4'hF);
    check("async reset best_t", b12.best_t, 32'h0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    idle_hits = 0;
    repeat (10) begin
      @(posedge clk_in); #1;
      if (b12.valid_out) idle_hits++;
    end
    check("no stale beat after reset", idle_hits, 0);

    tv = {12{32'h3C00_0000}}; tv[0] = 32'h4000_0000;
    beat12("after reset", 12'h001, tv, 11'h044, 10'h055, 96'h66, 4'd0, 32'h4000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
